// File: rtl/pipeline_hazard_ctrl_if.sv
// Stall/flush control bundle between the pipeline and the hazard controller.
// master = pipeline datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_addr_id;
    logic [4:0]       rs2_addr_id;
    logic             rs1_valid_id;
    logic             rs2_valid_id;
    logic [4:0]       rd_addr_ex;
    logic             rd_valid_ex;
    logic             is_load_ex;
    logic             branch_taken_ex;
    logic             mem_req;
    logic             mem_ready;
    logic             halt_req;

    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1_addr_id, rs2_addr_id,
        output rs1_valid_id, rs2_valid_id,
        output rd_addr_ex, rd_valid_ex,
        output is_load_ex, branch_taken_ex,
        output mem_req, mem_ready, halt_req,
        input  stall_if, stall_id,
        input  stall_ex, stall_mem,
        input  flush_if_id, flush_id_ex,
        input  halted, mem_timeout,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_addr_id, rs2_addr_id,
        input  rs1_valid_id, rs2_valid_id,
        input  rd_addr_ex, rd_valid_ex,
        input  is_load_ex, branch_taken_ex,
        input  mem_req, mem_ready, halt_req,
        output stall_if, stall_id,
        output stall_ex, stall_mem,
        output flush_if_id, flush_id_ex,
        output halted, mem_timeout,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use bubble, dmem freeze,
// branch flush, debug halt/drain and saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
    localparam int DRN_W  = $clog2(DRAIN_CYCLES + 2);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [DRN_W-1:0]  drain_cnt;
    logic              timeout_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic mem_busy;
    logic branch;

    logic s_if;
    logic s_id;
    logic s_ex;
    logic s_mem;
    logic f_if_id;
    logic f_id_ex;
    logic halt_o;

    assign rs1_hit = hz.rs1_valid_id &&
                     (hz.rs1_addr_id == hz.rd_addr_ex);
    assign rs2_hit = hz.rs2_valid_id &&
                     (hz.rs2_addr_id == hz.rd_addr_ex);

    assign load_use = hz.is_load_ex && hz.rd_valid_ex &&
                      (hz.rd_addr_ex != 5'd0) &&
                      (rs1_hit || rs2_hit);

    assign mem_busy = hz.mem_req && !hz.mem_ready;
    assign branch   = hz.branch_taken_ex;
    assign wait_nxt = wait_cnt + 1'b1;

    // Zero-latency controls; forced low while reset is asserted.
    always_comb begin
        s_if    = 1'b0;
        s_id    = 1'b0;
        s_ex    = 1'b0;
        s_mem   = 1'b0;
        f_if_id = 1'b0;
        f_id_ex = 1'b0;
        halt_o  = 1'b0;
        if (rst_n) begin
            unique case (state)
                RUN, MEM_WAIT: begin
                    unique case (1'b1)
                        mem_busy: begin
                            s_if  = 1'b1;
                            s_id  = 1'b1;
                            s_ex  = 1'b1;
                            s_mem = 1'b1;
                        end
                        (!mem_busy && branch): begin
                            f_if_id = 1'b1;
                            f_id_ex = 1'b1;
                        end
                        (!mem_busy && !branch && load_use): begin
                            s_if    = 1'b1;
                            s_id    = 1'b1;
                            f_id_ex = 1'b1;
                        end
                        default: ;
                    endcase
                end
                DRAIN: begin
                    if (mem_busy) begin
                        s_if  = 1'b1;
                        s_id  = 1'b1;
                        s_ex  = 1'b1;
                        s_mem = 1'b1;
                    end else begin
                        s_if    = 1'b1;
                        f_if_id = 1'b1;
                        f_id_ex = branch;
                    end
                end
                HALTED: begin
                    halt_o = 1'b1;
                    s_if   = 1'b1;
                    s_id   = 1'b1;
                    s_ex   = 1'b1;
                    s_mem  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_busy) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end else if (hz.halt_req && !branch) begin
                        state     <= DRAIN;
                        drain_cnt <= DRN_W'(DRAIN_CYCLES);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_busy) begin
                        state <= RUN;
                    end else begin
                        if (wait_cnt != WAIT_W'(MEM_TIMEOUT))
                            wait_cnt <= wait_nxt;
                        if (wait_nxt >= WAIT_W'(MEM_TIMEOUT))
                            timeout_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Dropping the request aborts the drain.
                    if (!hz.halt_req) begin
                        state <= RUN;
                    end else if (!mem_busy) begin
                        drain_cnt <= drain_cnt - 1'b1;
                        if (drain_cnt <= DRN_W'(1))
                            state <= HALTED;
                    end
                end
                HALTED: begin
                    if (!hz.halt_req)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase

            if (s_if && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if (branch && f_if_id && (flush_q != '1))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign hz.stall_if    = s_if;
    assign hz.stall_id    = s_id;
    assign hz.stall_ex    = s_ex;
    assign hz.stall_mem   = s_mem;
    assign hz.flush_if_id = f_if_id;
    assign hz.flush_id_ex = f_id_ex;
    assign hz.halted      = halt_o;
    assign hz.mem_timeout = timeout_q;
    assign hz.stall_cnt   = stall_q;
    assign hz.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic,
// all compared with a rule-level reference model.
module tb_pipeline_hazard_ctrl;
    localparam int CW  = 8;
    localparam int TMO = 255;
    localparam int DRN = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (TMO),
        .DRAIN_CYCLES(DRN),
        .CNT_W       (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    int checks   = 0;
    int failures = 0;

    // Model: halt progress, drain bubbles left, busy run length.
    bit m_drain, m_halt, m_tmo;
    int m_left, m_run, m_scnt, m_fcnt;
    bit e_sif, e_sid, e_sex, e_smem, e_fii, e_fie, e_hlt;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit busy_now();
        return hz.mem_req && !hz.mem_ready;
    endfunction

    function automatic bit lu_now();
        bit h1, h2;
        h1 = hz.rs1_valid_id && hz.rs1_addr_id == hz.rd_addr_ex;
        h2 = hz.rs2_valid_id && hz.rs2_addr_id == hz.rd_addr_ex;
        return hz.is_load_ex && hz.rd_valid_ex &&
               hz.rd_addr_ex != 0 && (h1 || h2);
    endfunction

    function automatic void predict();
        bit b, br;
        b  = busy_now();
        br = hz.branch_taken_ex;
        {e_sif, e_sid, e_sex, e_smem, e_fii, e_fie, e_hlt} = '0;
        if (!rst_n) return;
        if (m_halt) begin
            {e_sif, e_sid, e_sex, e_smem, e_hlt} = '1;
        end else if (m_drain) begin
            if (b) {e_sif, e_sid, e_sex, e_smem} = '1;
            else begin
                e_sif = 1; e_fii = 1; e_fie = br;
            end
        end else if (b) begin
            {e_sif, e_sid, e_sex, e_smem} = '1;
        end else if (br) begin
            e_fii = 1; e_fie = 1;
        end else if (lu_now()) begin
            e_sif = 1; e_sid = 1; e_fie = 1;
        end
    endfunction

    function automatic void update();
        bit b, br, hr;
        b  = busy_now();
        br = hz.branch_taken_ex;
        hr = hz.halt_req;
        if (!rst_n) begin
            {m_drain, m_halt, m_tmo} = '0;
            m_left = 0; m_run = 0; m_scnt = 0; m_fcnt = 0;
            return;
        end
        if (e_sif && m_scnt < CMAX) m_scnt++;
        if (br && e_fii && m_fcnt < CMAX) m_fcnt++;
        if (m_halt) begin
            m_run = 0;
            if (!hr) m_halt = 0;
        end else if (m_drain) begin
            m_run = 0;
            if (!hr) m_drain = 0;
            else if (!b) begin
                m_left--;
                if (m_left == 0) begin
                    m_drain = 0; m_halt = 1;
                end
            end
        end else if (b) begin
            m_run++;
            if (m_run > TMO) m_tmo = 1;
        end else begin
            if (m_run == 0 && hr && !br) begin
                m_drain = 1; m_left = DRN;
            end
            m_run = 0;
        end
    endfunction

    task automatic cycle();
        @(negedge clk);
        predict();
        chk("stall_if",    32'(hz.stall_if),    32'(e_sif));
        chk("stall_id",    32'(hz.stall_id),    32'(e_sid));
        chk("stall_ex",    32'(hz.stall_ex),    32'(e_sex));
        chk("stall_mem",   32'(hz.stall_mem),   32'(e_smem));
        chk("flush_if_id", 32'(hz.flush_if_id), 32'(e_fii));
        chk("flush_id_ex", 32'(hz.flush_id_ex), 32'(e_fie));
        chk("halted",      32'(hz.halted),      32'(e_hlt));
        chk("mem_timeout", 32'(hz.mem_timeout), 32'(m_tmo));
        chk("stall_cnt",   32'(hz.stall_cnt),   32'(m_scnt));
        chk("flush_cnt",   32'(hz.flush_cnt),   32'(m_fcnt));
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic idle();
        hz.rs1_addr_id = 0; hz.rs2_addr_id = 0;
        hz.rs1_valid_id = 0; hz.rs2_valid_id = 0;
        hz.rd_addr_ex = 0; hz.rd_valid_ex = 0;
        hz.is_load_ex = 0; hz.branch_taken_ex = 0;
        hz.mem_req = 0; hz.mem_ready = 0; hz.halt_req = 0;
    endtask

    task automatic set_lu(logic [4:0] rd, logic [4:0] rs2);
        hz.is_load_ex = 1; hz.rd_valid_ex = 1;
        hz.rd_addr_ex = rd;
        hz.rs2_valid_id = 1; hz.rs2_addr_id = rs2;
    endtask

    initial begin
        idle();
        rst_n = 0;
        m_scnt = 0; m_fcnt = 0;
        #1;
        cycle();
        cycle();
        chk("rst_stall_cnt", 32'(hz.stall_cnt), 0);
        chk("rst_halted", 32'(hz.halted), 0);
        rst_n = 1;
        cycle();

        // Load-use on rs2 gives a single bubble.
        set_lu(5'd5, 5'd5);
        #1;
        chk("lu_stall_if", 32'(hz.stall_if), 1);
        chk("lu_flush_id_ex", 32'(hz.flush_id_ex), 1);
        chk("lu_stall_ex", 32'(hz.stall_ex), 0);
        cycle();
        idle();
        #1;
        chk("lu_after_stall_if", 32'(hz.stall_if), 0);
        chk("lu_stall_cnt", 32'(hz.stall_cnt), 1);
        cycle();
        set_lu(5'd0, 5'd0);
        #1;
        chk("x0_no_stall", 32'(hz.stall_if), 0);
        cycle();
        idle();

        // Four-cycle dmem wait.
        hz.mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mw_stall_mem", 32'(hz.stall_mem), 1);
            chk("mw_flush", 32'(hz.flush_if_id), 0);
            cycle();
        end
        hz.mem_ready = 1;
        #1;
        chk("mw_release", 32'(hz.stall_if), 0);
        cycle();
        idle();
        cycle();
        chk("mw_stall_cnt", 32'(hz.stall_cnt), 5);

        // Branch beats load-use, then branch deferred by busy dmem.
        set_lu(5'd7, 5'd7);
        hz.branch_taken_ex = 1;
        #1;
        chk("br_flush_if_id", 32'(hz.flush_if_id), 1);
        chk("br_flush_id_ex", 32'(hz.flush_id_ex), 1);
        chk("br_stall_if", 32'(hz.stall_if), 0);
        cycle();
        idle();
        #1;
        chk("br_flush_cnt", 32'(hz.flush_cnt), 1);
        hz.branch_taken_ex = 1;
        hz.mem_req = 1;
        repeat (2) begin
            #1;
            chk("br_defer", 32'(hz.flush_if_id), 0);
            cycle();
        end
        hz.mem_ready = 1;
        #1;
        chk("br_release", 32'(hz.flush_if_id), 1);
        cycle();
        idle();
        #1;
        chk("br_flush_cnt2", 32'(hz.flush_cnt), 2);

        // Halt, drain three bubbles, then resume.
        hz.halt_req = 1;
        cycle();
        for (int i = 0; i < DRN; i++) begin
            #1;
            chk("drn_stall_if", 32'(hz.stall_if), 1);
            chk("drn_flush_if_id", 32'(hz.flush_if_id), 1);
            chk("drn_stall_id", 32'(hz.stall_id), 0);
            chk("drn_halted", 32'(hz.halted), 0);
            cycle();
        end
        repeat (2) begin
            #1;
            chk("hlt_halted", 32'(hz.halted), 1);
            chk("hlt_stall_mem", 32'(hz.stall_mem), 1);
            cycle();
        end
        hz.halt_req = 0;
        cycle();
        #1;
        chk("resume_halted", 32'(hz.halted), 0);
        chk("resume_stall_if", 32'(hz.stall_if), 0);
        cycle();

        // Dmem timeout boundary; also saturates the 8-bit stall counter.
        hz.mem_req = 1;
        repeat (TMO) cycle();
        chk("tmo_not_yet", 32'(hz.mem_timeout), 0);
        cycle();
        chk("tmo_set", 32'(hz.mem_timeout), 1);
        hz.mem_ready = 1;
        cycle();
        idle();
        cycle();
        chk("tmo_sticky", 32'(hz.mem_timeout), 1);
        chk("stall_sat", 32'(hz.stall_cnt), CMAX);
        set_lu(5'd3, 5'd3);
        cycle();
        idle();
        chk("stall_sat_hold", 32'(hz.stall_cnt), CMAX);

        // Reset in the middle of a drain.
        hz.halt_req = 1;
        cycle();
        cycle();
        rst_n = 0;
        #1;
        chk("rst_gate", 32'(hz.stall_if), 0);
        cycle();
        rst_n = 1;
        hz.halt_req = 0;
        #1;
        chk("rst_drn_cnt", 32'(hz.stall_cnt), 0);
        chk("rst_drn_tmo", 32'(hz.mem_timeout), 0);
        chk("rst_drn_sif", 32'(hz.stall_if), 0);
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            hz.rs1_addr_id = 5'($urandom_range(0, 3));
            hz.rs2_addr_id = 5'($urandom_range(0, 3));
            hz.rd_addr_ex  = 5'($urandom_range(0, 3));
            hz.rs1_valid_id = 1'($urandom);
            hz.rs2_valid_id = 1'($urandom);
            hz.rd_valid_ex  = 1'($urandom);
            hz.is_load_ex   = 1'($urandom);
            hz.branch_taken_ex = ($urandom_range(0, 5) == 0);
            hz.mem_req   = ($urandom_range(0, 2) == 0);
            hz.mem_ready = 1'($urandom);
            if ($urandom_range(0, 15) == 0)
                hz.halt_req = ~hz.halt_req;
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
